// File: rtl/relu_stream_out.sv
// Buffers packed ReLU words from the packer and replays them as an AXI4-Stream
// master with frame TLAST, occupancy reporting and a sticky overflow flag.
module relu_stream_out #(
  parameter int DATA_WIDTH         = 128,
  parameter int FIFO_DEPTH         = 64,
  parameter int FRAME_BEATS        = 400,
  parameter int ALMOST_FULL_MARGIN = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          almost_full,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] AF_THRESH = LW'(FIFO_DEPTH - ALMOST_FULL_MARGIN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_next;
  logic [BW-1:0]         beat_cnt;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;

  logic pop;
  logic push;
  logic full;
  logic mem_empty;
  logic load;
  logic bypass;
  logic mem_write;

  assign pop       = tvalid_q & m_axis_tready;
  assign full      = (level_q == DEPTH_L);
  assign push      = in_valid & (~full | pop);
  assign mem_empty = (wr_ptr == rd_ptr);
  assign load      = ~tvalid_q | pop;
  assign bypass    = load & mem_empty & push;
  assign mem_write = push & ~bypass;

  always_comb begin
    level_next = level_q;
    case ({push, pop})
      2'b10:   level_next = level_q + LW'(1);
      2'b01:   level_next = level_q - LW'(1);
      default: level_next = level_q;
    endcase
  end

  // Storage has no reset so it can map onto block RAM; pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && mem_write) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
      beat_cnt    <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
    end else begin
      if (mem_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      // Output register reloads whenever it is empty or being consumed.
      if (load) begin
        if (!mem_empty) begin
          tdata_q  <= mem[rd_ptr[AW-1:0]];
          rd_ptr   <= rd_ptr + PTR_ONE;
          tvalid_q <= 1'b1;
        end else if (push) begin
          tdata_q  <= in_data;
          tvalid_q <= 1'b1;
        end else begin
          tvalid_q <= 1'b0;
        end
      end

      level_q     <= level_next;
      almost_full <= (level_next >= AF_THRESH);

      if (in_valid && full && !pop) begin
        overflow <= 1'b1;
      end

      if (pop) begin
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
      end

      frame_done <= pop & m_axis_tlast;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q & (beat_cnt == LAST_BEAT);
  assign m_axis_tkeep  = '1;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_relu_stream_out.sv
// Directed bench for relu_stream_out: pass-through, backpressure, overflow,
// full-with-pop, framing under random tready, and mid-frame reset.
module tb_relu_stream_out;

  localparam int DW    = 128;
  localparam int DEPTH = 64;
  localparam int BEATS = 400;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [DW/8-1:0] m_axis_tkeep;
  logic [6:0]      fifo_level;
  logic            almost_full;
  logic            overflow;
  logic            frame_done;

  int vecCount  = 0;
  int missCount = 0;

  relu_stream_out #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .FRAME_BEATS(BEATS),
    .ALMOST_FULL_MARGIN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tkeep(m_axis_tkeep),
    .fifo_level(fifo_level),
    .almost_full(almost_full),
    .overflow(overflow),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Drive inputs, then advance one clock and settle just after the edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid      = v;
    in_data       = d;
    m_axis_tready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] expQ[$];
    int  pushed;
    int  popped;
    int  doneCount;
    int  n;
    logic expDone;
    logic rdy;
    logic vin;

    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    m_axis_tready = 1'b0;

    // Reset and idle.
    doReset(2);
    checkOutput("rst_tvalid", DW'(m_axis_tvalid), '0);
    checkOutput("rst_tlast",  DW'(m_axis_tlast),  '0);
    checkOutput("rst_tdata",  m_axis_tdata,       '0);
    checkOutput("rst_level",  DW'(fifo_level),    '0);
    checkOutput("rst_afull",  DW'(almost_full),   '0);
    checkOutput("rst_ovf",    DW'(overflow),      '0);
    checkOutput("rst_done",   DW'(frame_done),    '0);
    checkOutput("tkeep",      DW'(m_axis_tkeep),  DW'(16'hFFFF));

    // Pass-through with tready high: one-cycle latency, level stays at 1.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b1);
      checkOutput("pt_tdata",  m_axis_tdata,       DW'(i));
      checkOutput("pt_tvalid", DW'(m_axis_tvalid), DW'(1));
      checkOutput("pt_level",  DW'(fifo_level),    DW'(1));
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("pt_empty", DW'(m_axis_tvalid), '0);
    checkOutput("pt_level0", DW'(fifo_level), '0);

    // Backpressure: ten words held, head stable, then drained in order.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, DW'(100 + i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("bp_level",  DW'(fifo_level),    DW'(10));
    checkOutput("bp_tvalid", DW'(m_axis_tvalid), DW'(1));
    checkOutput("bp_hold",   m_axis_tdata,       DW'(100));
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("bp_hold2",  m_axis_tdata,       DW'(100));
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_order", m_axis_tdata, DW'(100 + i));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("bp_level0", DW'(fifo_level),    '0);
    checkOutput("bp_empty",  DW'(m_axis_tvalid), '0);

    // Overflow: 66 words into a 64-deep block with the sink stalled.
    for (int i = 0; i < 66; i++) begin
      applyStimulus(1'b1, DW'(200 + i), 1'b0);
      n = (i + 1 > DEPTH) ? DEPTH : i + 1;
      checkOutput("ov_level", DW'(fifo_level),  DW'(n));
      checkOutput("ov_afull", DW'(almost_full), DW'(n >= 56));
      checkOutput("ov_flag",  DW'(overflow),    DW'(i >= 64));
    end
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      checkOutput("ov_drain", m_axis_tdata, DW'(200 + i));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("ov_empty",  DW'(m_axis_tvalid), '0);
    checkOutput("ov_sticky", DW'(overflow),      DW'(1));

    // Full with simultaneous push and pop must not overflow.
    doReset(2);
    checkOutput("rst2_ovf", DW'(overflow), '0);
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, DW'(300 + i), 1'b0);
    checkOutput("fp_level", DW'(fifo_level), DW'(64));
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, DW'(364 + k), 1'b1);
      checkOutput("fp_tdata", m_axis_tdata,    DW'(301 + k));
      checkOutput("fp_level", DW'(fifo_level), DW'(64));
      checkOutput("fp_ovf",   DW'(overflow),   '0);
    end
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      checkOutput("fp_drain", m_axis_tdata, DW'(305 + i));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("fp_empty", DW'(m_axis_tvalid), '0);

    // Framing: 800 words, random tready, upstream stalls on almost_full.
    doReset(2);
    pushed = 0;
    popped = 0;
    doneCount = 0;
    expDone = 1'b0;
    for (int cyc = 0; cyc < 20000 && popped < 800; cyc++) begin
      rdy = 1'($urandom_range(0, 1));
      vin = (pushed < 800) && !almost_full;
      if (m_axis_tvalid && rdy) begin
        if (expQ.size() == 0) begin
          checkOutput("frm_extra", DW'(1), '0);
        end else begin
          checkOutput("frm_data", m_axis_tdata, expQ.pop_front());
        end
        checkOutput("frm_last", DW'(m_axis_tlast), DW'((popped % BEATS) == BEATS - 1));
        expDone = ((popped % BEATS) == BEATS - 1);
        popped++;
      end else begin
        expDone = 1'b0;
      end
      if (vin) begin
        expQ.push_back(DW'(1000 + pushed));
        pushed++;
      end
      applyStimulus(vin, DW'(1000 + pushed - (vin ? 1 : 0)), rdy);
      checkOutput("frm_done", DW'(frame_done), DW'(expDone));
      if (frame_done) doneCount++;
    end
    checkOutput("frm_count", DW'(popped),    DW'(800));
    checkOutput("frm_pulses", DW'(doneCount), DW'(2));
    checkOutput("frm_ovf",   DW'(overflow),  '0);

    // Third frame reset mid-way: count restarts from the reset.
    applyStimulus(1'b0, '0, 1'b1);
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1'b1, DW'(3000 + k), 1'b1);
      checkOutput("f3_last", DW'(m_axis_tlast), '0);
    end
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, DW'(3500 + k), 1'b0);
    doReset(1);
    checkOutput("mr_level",  DW'(fifo_level),    '0);
    checkOutput("mr_tvalid", DW'(m_axis_tvalid), '0);
    for (int k = 0; k < BEATS; k++) begin
      applyStimulus(1'b1, DW'(5000 + k), 1'b1);
      checkOutput("mr_tdata", m_axis_tdata,       DW'(5000 + k));
      checkOutput("mr_last",  DW'(m_axis_tlast),  DW'(k == BEATS - 1));
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mr_done",  DW'(frame_done),    DW'(1));
    checkOutput("mr_empty", DW'(m_axis_tvalid), '0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mr_done_end", DW'(frame_done), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
